// File: rtl/hazard_pkg.sv
// Shared types and constants for the Filter-GPU hazard controller.
// Optional perf counters in hazard_ctrl are enabled by HAZ_PERF_CNT_EN.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  localparam int MEM_LAT_MAX = 16;
  localparam int MEM_CNT_W   = $clog2(MEM_LAT_MAX);

  // The M-stage result is younger than W, so it wins when both match.
  function automatic fwd_sel_t fwd_sel(input logic m_hit, input logic w_hit);
    if (m_hit)
      return FWD_MEM;
    else if (w_hit)
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_mem_timer.sv
// Memory-wait sequencer: holds the M stage for MEM_LAT-1 cycles per memory op.
// Reset aborts an in-flight wait; the op is not resumed.
module hazard_mem_timer
  import hazard_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic MemReqM,
  output logic memstall,
  output logic MemBusy
);

  localparam bit HAS_WAIT = (MEM_LAT > 1);
  localparam logic [MEM_CNT_W-1:0] CNT_INIT =
    HAS_WAIT ? MEM_CNT_W'(MEM_LAT - 2) : '0;

  mem_state_t             state_reg, state_next;
  logic [MEM_CNT_W-1:0]   cnt_reg, cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    memstall   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (MemReqM && HAS_WAIT) begin
          memstall   = 1'b1;
          cnt_next   = CNT_INIT;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // Final BUSY cycle belongs to the same op, so MemReqM is not sampled.
        if (cnt_reg != '0) begin
          memstall = 1'b1;
          cnt_next = cnt_reg - 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (reset)
      memstall = 1'b0;
  end

  assign MemBusy = (state_reg == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: E-stage forwarding, load-use stall, branch flush, memory wait.
// Define HAZ_PERF_CNT_EN to add saturating StallCnt/FlushCnt perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int MEM_LAT    = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] RA1D,
  input  logic [REG_ADDR_W-1:0] RA2D,
  input  logic [REG_ADDR_W-1:0] RA1E,
  input  logic [REG_ADDR_W-1:0] RA2E,
  input  logic [REG_ADDR_W-1:0] WA3E,
  input  logic [REG_ADDR_W-1:0] WA3M,
  input  logic [REG_ADDR_W-1:0] WA3W,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegE,
  input  logic                  MemReqM,
  input  logic                  BranchTakenE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic                  MemBusy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      StallCnt,
  output logic [CNT_W-1:0]      FlushCnt
`endif
);

  if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
    $error("hazard_ctrl: MEM_LAT out of range");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_ctrl: CNT_W must be positive");
  end

  logic memstall;
  logic ldr;

  hazard_mem_timer #(
    .MEM_LAT (MEM_LAT)
  ) u_mem_timer (
    .clk      (clk),
    .reset    (reset),
    .MemReqM  (MemReqM),
    .memstall (memstall),
    .MemBusy  (MemBusy)
  );

  assign ForwardAE = fwd_sel(RegWriteM && (RA1E == WA3M), RegWriteW && (RA1E == WA3W));
  assign ForwardBE = fwd_sel(RegWriteM && (RA2E == WA3M), RegWriteW && (RA2E == WA3W));

  assign ldr = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));

  // Memory wait freezes everything, including a pending branch; branch beats load-use.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (memstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (BranchTakenE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (ldr) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (StallD && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (FlushE && (flush_cnt_reg != {CNT_W{1'b1}}))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign StallCnt = stall_cnt_reg;
  assign FlushCnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: four instances with MEM_LAT = 4, 3, 8, 1.
// Counter checks are included when HAZ_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

  localparam int N_INST = 4;
  localparam int LATS[N_INST] = '{4, 3, 8, 1};

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE, MemReqM, BranchTakenE;

  logic [1:0]  fa [N_INST];
  logic [1:0]  fb [N_INST];
  logic        sf [N_INST], sd [N_INST], se [N_INST], sm [N_INST];
  logic        fd [N_INST], fe [N_INST], fw [N_INST], mb [N_INST];
  logic [11:0] act [N_INST];
  logic [3:0]  scnt [N_INST];
  logic [3:0]  fcnt [N_INST];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N_INST; gi++) begin : g_dut
    hazard_ctrl #(
      .REG_ADDR_W (4),
      .MEM_LAT    (LATS[gi]),
      .CNT_W      (4)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .RA1D         (RA1D),
      .RA2D         (RA2D),
      .RA1E         (RA1E),
      .RA2E         (RA2E),
      .WA3E         (WA3E),
      .WA3M         (WA3M),
      .WA3W         (WA3W),
      .RegWriteM    (RegWriteM),
      .RegWriteW    (RegWriteW),
      .MemtoRegE    (MemtoRegE),
      .MemReqM      (MemReqM),
      .BranchTakenE (BranchTakenE),
      .ForwardAE    (fa[gi]),
      .ForwardBE    (fb[gi]),
      .StallF       (sf[gi]),
      .StallD       (sd[gi]),
      .StallE       (se[gi]),
      .StallM       (sm[gi]),
      .FlushD       (fd[gi]),
      .FlushE       (fe[gi]),
      .FlushW       (fw[gi]),
      .MemBusy      (mb[gi])
`ifdef HAZ_PERF_CNT_EN
      ,
      .StallCnt     (scnt[gi]),
      .FlushCnt     (fcnt[gi])
`endif
    );
`ifndef HAZ_PERF_CNT_EN
    assign scnt[gi] = '0;
    assign fcnt[gi] = '0;
`endif
    assign act[gi] = {fa[gi], fb[gi], sf[gi], sd[gi], se[gi], sm[gi],
                      fd[gi], fe[gi], fw[gi], mb[gi]};
  end

  typedef struct {
    string       name;
    int          inst;
    bit          is_cnt;
    logic [11:0] vec;
    logic [3:0]  sc;
    logic [3:0]  fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Output vector layout: {ForwardAE, ForwardBE, StallF/D/E/M, FlushD/E/W, MemBusy}
  function automatic logic [11:0] mk(input logic [1:0] a, input logic [1:0] b,
                                     input logic [3:0] st, input logic [2:0] fl,
                                     input logic busy);
    return {a, b, st, fl, busy};
  endfunction

  function automatic logic [11:0] ms(input logic busy);
    return mk(2'b00, 2'b00, 4'b1111, 3'b001, busy);
  endfunction

  localparam logic [11:0] Z   = 12'b0;
  localparam logic [11:0] LDR = {2'b00, 2'b00, 4'b1100, 3'b010, 1'b0};
  localparam logic [11:0] BR  = {2'b00, 2'b00, 4'b0000, 3'b110, 1'b0};

  task automatic expect_out(input string name, input int inst, input logic [11:0] v);
    exp_t e;
    e.name = name; e.inst = inst; e.is_cnt = 1'b0; e.vec = v; e.sc = '0; e.fc = '0;
    q.push_back(e);
  endtask

  task automatic expect_cnt(input string name, input int inst,
                            input logic [3:0] s, input logic [3:0] f);
    exp_t e;
    e.name = name; e.inst = inst; e.is_cnt = 1'b1; e.vec = '0; e.sc = s; e.fc = f;
    q.push_back(e);
  endtask

  // Monitor: outputs are combinational, so every queued expectation is due at the next negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (e.is_cnt) begin
          if (scnt[e.inst] !== e.sc || fcnt[e.inst] !== e.fc) begin
            errors++;
            $display("FAIL %s inst%0d: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                     e.name, e.inst, scnt[e.inst], fcnt[e.inst], e.sc, e.fc);
          end else
            $display("ok   %s inst%0d stall=%0d flush=%0d", e.name, e.inst, e.sc, e.fc);
        end else begin
          if (act[e.inst] !== e.vec) begin
            errors++;
            $display("FAIL %s inst%0d: got %b expected %b", e.name, e.inst, act[e.inst], e.vec);
          end else
            $display("ok   %s inst%0d %b", e.name, e.inst, e.vec);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0;
    WA3E = '0; WA3M = '0; WA3W = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    MemReqM = 1'b0; BranchTakenE = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    zero_inputs();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    zero_inputs();
    for (int i = 0; i < N_INST; i++) expect_out("reset", i, Z);
    tick();
    tick();
    reset = 1'b0;

    // Forwarding
    RA1E = 4'd3; RA2E = 4'd3; WA3M = 4'd3; WA3W = 4'd3; RegWriteM = 1'b1; RegWriteW = 1'b1;
    expect_out("fwd_mem_wins", 0, mk(2'b10, 2'b10, 4'b0, 3'b0, 1'b0));
    tick(); RegWriteM = 1'b0;
    expect_out("fwd_wb", 0, mk(2'b01, 2'b01, 4'b0, 3'b0, 1'b0));
    tick(); RegWriteW = 1'b0;
    expect_out("fwd_none", 0, Z);
    tick(); RA2E = 4'd9; WA3W = 4'd9; RegWriteW = 1'b1; RegWriteM = 1'b1;
    expect_out("fwd_split", 0, mk(2'b10, 2'b01, 4'b0, 3'b0, 1'b0));

    // Load-use and branch priority
    tick(); zero_inputs(); MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
    expect_out("ldr_ra2", 0, LDR);
    tick(); RA2D = 4'd6;
    expect_out("ldr_miss", 0, Z);
    tick(); RA1D = 4'd5;
    expect_out("ldr_ra1", 0, LDR);
    tick(); BranchTakenE = 1'b1;
    expect_out("br_over_ldr", 0, BR);

    // Memory wait, MEM_LAT=4, request held (second op follows with no gap)
    do_reset();
    MemReqM = 1'b1;
    expect_out("mem_c1", 0, ms(1'b0));
    expect_out("lat1_no_wait", 3, Z);
    tick(); expect_out("mem_c2", 0, ms(1'b1));
    tick(); expect_out("mem_c3", 0, ms(1'b1));
    tick(); expect_out("mem_c4_done", 0, mk(2'b0, 2'b0, 4'b0, 3'b0, 1'b1));
    tick(); expect_out("mem_b2b", 0, ms(1'b0));
    expect_out("lat1_idle", 3, Z);

    // Priority during wait, MEM_LAT=3
    do_reset();
    MemReqM = 1'b1; BranchTakenE = 1'b1; MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
    expect_out("prio_c1", 1, ms(1'b0));
    tick(); MemReqM = 1'b0;
    expect_out("prio_busy", 1, ms(1'b1));
    tick(); expect_out("prio_end_br", 1, BR | 12'b1);
    tick(); expect_out("prio_idle_br", 1, BR);

    // Reset mid-op, MEM_LAT=8
    do_reset();
    MemReqM = 1'b1;
    expect_out("rst_c1", 2, ms(1'b0));
    tick(); MemReqM = 1'b0;
    expect_out("rst_c2", 2, ms(1'b1));
    tick(); reset = 1'b1;
    expect_out("rst_async", 2, Z);
    tick(); reset = 1'b0;
    expect_out("rst_after", 2, Z);
    tick(); expect_out("rst_after2", 2, Z);

`ifdef HAZ_PERF_CNT_EN
    do_reset();
    MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 3)  expect_cnt("cnt_3", 0, 4'd3, 4'd3);
      if (i == 20) expect_cnt("cnt_sat", 0, 4'd15, 4'd15);
    end
`endif

    for (int k = 0; k < 100 && q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the Filter-GPU five-stage pipeline. Two functions:
- Forwarding-mux selects for the E-stage operands.
- Load-use stalls, with branch-taken flushes taking priority.

It adds a multi-cycle memory-wait sequencer, so vector/pixel memory with latency MEM_LAT holds the M stage and stalls upstream stages. It sits beside the datapath and drives the stall/flush enables of every pipeline register.

## Interface
Parameters:
- REG_ADDR_W, 4, register-address width (register file depth = 2**REG_ADDR_W)
- MEM_LAT, 1, cycles a memory op occupies M (legal 1..16; 1 = no wait states)
- CNT_W, 32, perf-counter width (used only with HAZ_PERF_CNT_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- RA1D, RA2D  in  REG_ADDR_W  D-stage source registers
- RA1E, RA2E  in  REG_ADDR_W  E-stage source registers
- WA3E, WA3M, WA3W  in  REG_ADDR_W  destination registers in E/M/W
- RegWriteM, RegWriteW  in  1  destination write enable in M/W
- MemtoRegE  in  1  E-stage instruction is a load
- MemReqM  in  1  M-stage instruction accesses memory
- BranchTakenE  in  1  branch resolved taken in E
- ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 ResultW, 10 ALUOutM
- StallF, StallD, StallE, StallM  out  1  hold pipeline register
- FlushD, FlushE, FlushW  out  1  insert bubble
- MemBusy  out  1  memory sequencer not IDLE
- StallCnt, FlushCnt  out  CNT_W  perf counters (only with HAZ_PERF_CNT_EN)

## Operation
Forwarding, per operand X ∈ {A,B}:
- RAxE==WA3M && RegWriteM → 10.
- Else RAxE==WA3W && RegWriteW → 01.
- Else 00.
- The M match wins when both match.

Load-use:
- ldr = MemtoRegE && (RA1D==WA3E || RA2D==WA3E).

Memory sequencer states:
- IDLE: if MemReqM && MEM_LAT>1 → memstall=1, cnt←MEM_LAT-2, go BUSY. Otherwise memstall=0.
- BUSY, cnt≠0: memstall=1, cnt←cnt-1.
- BUSY, cnt==0: memstall=0, go IDLE. MemReqM is ignored in this cycle (same op completing).
- Result: a memory op causes exactly MEM_LAT-1 stall cycles.

Output priority:
- memstall=1:
  - StallF=StallD=StallE=StallM=1, FlushW=1.
  - FlushD=FlushE=0: BranchTakenE is held and re-evaluated, and ldr is masked.
- Else BranchTakenE=1:
  - FlushD=FlushE=1, StallF=StallD=0.
  - ldr is suppressed because the D instruction is wrong-path.
- Else ldr=1: StallF=StallD=1, FlushE=1.
- Else: all stall/flush outputs 0.
- StallE, StallM and FlushW are 1 only under memstall.

MemBusy = (state==BUSY).

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and the registered sequencer state: zero-cycle latency.
- Sequencer state and cnt update on the clk rising edge.
- On reset (asynchronous): state=IDLE, cnt=0, MemBusy=0, perf counters=0.
- While reset is high, memstall is forced 0. All stall/flush outputs are therefore driven only by the combinational ldr/branch terms, which are 0 when their inputs are 0.
- Reset asserted mid-BUSY aborts the wait immediately. The op is not resumed.
- MEM_LAT=1 → the sequencer never leaves IDLE and MemBusy stays 0.
- Back-to-back memory ops: the second op enters IDLE→BUSY in the cycle after the first op's final BUSY cycle. No dead cycle.

## Configuration
HAZ_PERF_CNT_EN:
- Defined:
  - StallCnt increments each cycle StallD=1.
  - FlushCnt increments each cycle FlushE=1.
  - Both saturate at 2**CNT_W-1 and clear on reset.
- Undefined: both ports and their registers are absent.

## Structure
- hazard_pkg:
  - fwd_sel_t enum: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - mem_state_t enum: IDLE, BUSY.
  - MEM_LAT_MAX=16 constant.
- Sub-module hazard_mem_timer holds the sequencer FSM and counter. Ports: clk, reset, MemReqM; outputs memstall, MemBusy.
- Forwarding, priority logic and perf counters live in hazard_ctrl.

## Test plan
- Forwarding: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 → ForwardAE=10. Then RegWriteM=0 → ForwardAE=01. Then RegWriteW=0 → 00.
- Load-use: MemtoRegE=1, WA3E=5, RA2D=5 → StallF=StallD=FlushE=1, StallE=0. Same with RA2D=6 → all 0.
- Memory wait, MEM_LAT=4: MemReqM=1 held → memstall for 3 cycles. MemBusy=1 for cycles 2–4. Cycle 4 has all stalls 0 and the state returns to IDLE.
- Priority: MEM_LAT=3 in BUSY with BranchTakenE=1 and ldr true → FlushD=FlushE=0, StallM=1. After wait ends with BranchTakenE=1 → FlushD=FlushE=1, StallD=0.
- Reset mid-op: MEM_LAT=8; assert reset in the 3rd stall cycle → MemBusy=0 asynchronously. After release, MemReqM=0 → no stalls.
- HAZ_PERF_CNT_EN, CNT_W=4: 20 consecutive ldr cycles → StallCnt=15 and FlushCnt=15 (saturated).
